rv_divider_xlen: RTL and testbench

RV_DIVIDER_XLEN -- requirements
Module: rv_divider_xlen

---
 rtl/rv_divider_xlen.sv | 169 ++++++++++++++++
 tb/tb_rv_divider_xlen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rv_divider_xlen.sv
// rtl/rv_divider_xlen.sv - iterative RISC-V DIV/DIVU/REM/REMU unit
//
// Restoring shift-subtract divider retiring BITS_PER_CYCLE quotient bits per
// cycle. States: IDLE -> PREP -> ITER (XLEN/BITS_PER_CYCLE cycles) -> FIX -> DONE.
// Divide-by-zero and signed overflow finish straight from PREP.
//
// Ports:
//   clk          clock, rising edge
//   resetn       asynchronous active-low reset
//   div_valid    request, held until div_ready; a start needs a low-to-high edge
//   divop        00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend     rs1
//   divisor      rs2
//   result       quotient or remainder, loaded on DONE entry
//   div_ready    one-cycle completion pulse (DONE)
//   busy         high in PREP, ITER and FIX
//   div_by_zero  captured divisor was zero, updated on DONE entry
module rv_divider_xlen #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            div_valid,
  input  logic [1:0]      divop,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] result,
  output logic            div_ready,
  output logic            busy,
  output logic            div_by_zero
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            valid_q;
  logic            armed_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] a_q;      // dividend, then its magnitude, then the quotient
  logic [XLEN-1:0] b_q;      // divisor, then its magnitude
  logic [XLEN-1:0] rem_q;
  logic            q_neg_q, r_neg_q;
  logic [CW-1:0]   cnt_q;

  logic            signed_op, start, is_zero, is_ovf, iter_last;
  logic [XLEN-1:0] a_abs, b_abs, q_fix, r_fix, sp_res;
  logic [XLEN-1:0] q_nxt, r_nxt;
  logic [XLEN:0]   trial;

  assign signed_op = ~op_q[0];
  // armed_q blocks a start until div_valid has been seen low after reset, so a
  // request held across reset release is not mistaken for a new one.
  assign start     = (state_q == S_IDLE) && div_valid && !valid_q && armed_q;
  assign is_zero   = (b_q == '0);
  assign is_ovf    = signed_op && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (&b_q);
  assign iter_last = (cnt_q == CW'(N - 1));

  assign a_abs  = (signed_op && a_q[XLEN-1]) ? -a_q : a_q;
  assign b_abs  = (signed_op && b_q[XLEN-1]) ? -b_q : b_q;
  assign q_fix  = q_neg_q ? -a_q : a_q;
  assign r_fix  = r_neg_q ? -rem_q : rem_q;
  assign sp_res = is_zero ? (op_q[1] ? a_q : '1) : (op_q[1] ? '0 : a_q);

  // Unrolled restoring steps: shift the next dividend bit into the partial
  // remainder, subtract the divisor when it fits and retire a quotient bit.
  always_comb begin
    r_nxt = rem_q;
    q_nxt = a_q;
    trial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      trial = {r_nxt, q_nxt[XLEN-1]};
      q_nxt = {q_nxt[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, b_q}) begin
        trial    = trial - {1'b0, b_q};
        q_nxt[0] = 1'b1;
      end
      r_nxt = trial[XLEN-1:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    div_ready = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_PREP;
      S_PREP: begin
        busy = 1'b1;
        if (!div_valid)            state_d = S_IDLE;
        else if (is_zero || is_ovf) state_d = S_DONE;
        else                       state_d = S_ITER;
      end
      S_ITER: begin
        busy = 1'b1;
        if (!div_valid)     state_d = S_IDLE;
        else if (iter_last) state_d = S_FIX;
      end
      S_FIX: begin
        busy = 1'b1;
        if (!div_valid) state_d = S_IDLE;
        else            state_d = S_DONE;
      end
      S_DONE: begin
        div_ready = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q     <= 1'b0;
      armed_q     <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      cnt_q       <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      valid_q <= div_valid;
      armed_q <= armed_q | ~div_valid;
      case (state_q)
        S_IDLE: if (start) begin
          a_q  <= dividend;
          b_q  <= divisor;
          op_q <= divop;
        end
        S_PREP: if (div_valid) begin
          if (is_zero || is_ovf) begin
            result      <= sp_res;
            div_by_zero <= is_zero;
          end else begin
            a_q     <= a_abs;
            b_q     <= b_abs;
            rem_q   <= '0;
            cnt_q   <= '0;
            q_neg_q <= signed_op & (a_q[XLEN-1] ^ b_q[XLEN-1]);
            r_neg_q <= signed_op & a_q[XLEN-1];
          end
        end
        S_ITER: if (div_valid) begin
          a_q   <= q_nxt;
          rem_q <= r_nxt;
          cnt_q <= cnt_q + CW'(1);
        end
        S_FIX: if (div_valid) begin
          result      <= op_q[1] ? r_fix : q_fix;
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_divider_xlen.sv
// tb/tb_rv_divider_xlen.sv - scoreboard bench for rv_divider_xlen (32/1 and 64/4)
module tb_rv_divider_xlen;

  logic        clk = 1'b0;
  logic        resetn;
  logic        v32, rdy32, busy32, dbz32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, res32;
  logic        v64, rdy64, busy64, dbz64;
  logic [1:0]  op64;
  logic [63:0] a64, b64, res64;

  always #5 clk = ~clk;

  rv_divider_xlen #(.XLEN(32), .BITS_PER_CYCLE(1)) dut32 (
    .clk(clk), .resetn(resetn), .div_valid(v32), .divop(op32),
    .dividend(a32), .divisor(b32), .result(res32), .div_ready(rdy32),
    .busy(busy32), .div_by_zero(dbz32)
  );

  rv_divider_xlen #(.XLEN(64), .BITS_PER_CYCLE(4)) dut64 (
    .clk(clk), .resetn(resetn), .div_valid(v64), .divop(op64),
    .dividend(a64), .divisor(b64), .result(res64), .div_ready(rdy64),
    .busy(busy64), .div_by_zero(dbz64)
  );

  typedef struct {
    logic [63:0] res;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic          g_rdy(input bit w);  return w ? rdy64  : rdy32;  endfunction
  function automatic logic          g_busy(input bit w); return w ? busy64 : busy32; endfunction
  function automatic logic          g_dbz(input bit w);  return w ? dbz64  : dbz32;  endfunction
  function automatic logic [63:0]   g_res(input bit w);  return w ? res64 : {32'h0, res32}; endfunction

  function automatic logic [31:0] m32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] x, y;
    x = a; y = b;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
    case (op)
      2'b00:   return x / y;
      2'b01:   return a / b;
      2'b10:   return x % y;
      default: return a % b;
    endcase
  endfunction

  function automatic logic [63:0] m64(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] x, y;
    x = a; y = b;
    if (b == 0) return op[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    if (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return op[1] ? 64'h0 : a;
    case (op)
      2'b00:   return x / y;
      2'b01:   return a / b;
      2'b10:   return x % y;
      default: return a % b;
    endcase
  endfunction

  task automatic drive(input bit w, input logic v, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    if (w) begin v64 = v; op64 = op; a64 = a; b64 = b; end
    else begin v32 = v; op32 = op; a32 = a[31:0]; b32 = b[31:0]; end
  endtask

  // Called at a negedge with div_valid low; that negedge begins cycle 0.
  task automatic do_op(input string tag, input bit w, input logic [1:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] er, input logic ed, input int el);
    exp_t e;
    int   lat;
    bit   got;
    int   extra;
    e.res = er; e.dbz = ed; e.lat = el;
    sb.push_back(e);
    drive(w, 1'b1, op, a, b);
    got = 0; lat = 0;
    for (int k = 1; k <= 200 && !got; k++) begin
      @(negedge clk);
      if (k == 1) check({tag, "_busy_prep"}, g_busy(w), 1'b1);
      if (g_rdy(w)) begin got = 1; lat = k; end
    end
    check({tag, "_ready_seen"}, got, 1'b1);
    if (sb.size() > 0) e = sb.pop_front();
    if (got) begin
      check({tag, "_result"}, g_res(w), e.res);
      check({tag, "_dbz"}, g_dbz(w), e.dbz);
      check({tag, "_latency"}, lat, e.lat);
    end
    // keep the request high past DONE: there must be no second pulse or restart
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (g_rdy(w) || g_busy(w)) extra++;
    end
    check({tag, "_no_restart"}, extra, 0);
    drive(w, 1'b0, op, a, b);
    @(negedge clk);
  endtask

  initial begin
    logic [1:0]  op;
    logic [63:0] a, b;
    int          seen;

    resetn = 1'b0;
    drive(0, 1'b0, 2'b00, 64'h0, 64'h0);
    drive(1, 1'b0, 2'b00, 64'h0, 64'h0);
    #1;
    check("rst_result32", res32, 32'h0);
    check("rst_ready32", rdy32, 1'b0);
    check("rst_busy32", busy32, 1'b0);
    check("rst_dbz32", dbz32, 1'b0);
    check("rst_result64", res64, 64'h0);
    check("rst_busy64", busy64, 1'b0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    do_op("div_neg7_2",  0, 2'b00, 64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFD, 1'b0, 35);
    do_op("rem_neg7_2",  0, 2'b10, 64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFF, 1'b0, 35);
    do_op("divu_5_0",    0, 2'b01, 64'h5, 64'h0, 64'hFFFF_FFFF, 1'b1, 2);
    do_op("div_ovf",     0, 2'b00, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1'b0, 2);
    do_op("rem_ovf",     0, 2'b10, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0, 1'b0, 2);
    do_op("divu_100_7",  0, 2'b01, 64'd100, 64'd7, 64'd14, 1'b0, 35);
    do_op("div_zero_s",  0, 2'b00, 64'hFFFF_FFF0, 64'h0, 64'hFFFF_FFFF, 1'b1, 2);
    for (int i = 0; i < 6; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = {32'h0, 32'($urandom)};
      b  = {32'h0, 32'($urandom) >> $urandom_range(0, 28)};
      if (b == 0) b = 64'h3;
      do_op("rand32", 0, op, a, b, {32'h0, m32(op, a[31:0], b[31:0])}, 1'b0, 35);
    end
    do_op("remu_5_0",    0, 2'b11, 64'h5, 64'h0, 64'h5, 1'b1, 2);

    // abort: drop div_valid in cycle 10
    drive(0, 1'b1, 2'b01, 64'd100, 64'd7);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rdy32) seen++;
    end
    v32 = 1'b0;
    @(negedge clk);
    check("abort_busy_c11", busy32, 1'b0);
    repeat (40) begin
      @(negedge clk);
      if (rdy32) seen++;
    end
    check("abort_no_ready", seen, 0);
    check("abort_result_held", res32, 32'h5);
    check("abort_dbz_held", dbz32, 1'b1);
    do_op("after_abort", 0, 2'b01, 64'd100, 64'd7, 64'd14, 1'b0, 35);

    do_op("x64_divu",    1, 2'b01, 64'd100, 64'd7, 64'd14, 1'b0, 19);
    do_op("x64_remu",    1, 2'b11, 64'd100, 64'd7, 64'd2, 1'b0, 19);
    do_op("x64_div_neg", 1, 2'b00, -64'sd100, 64'd7, -64'sd14, 1'b0, 19);
    do_op("x64_rem_neg", 1, 2'b10, -64'sd100, 64'd7, -64'sd2, 1'b0, 19);
    do_op("x64_ovf",     1, 2'b00, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 1'b0, 2);
    for (int i = 0; i < 4; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = {32'($urandom), 32'($urandom)};
      b  = {32'($urandom), 32'($urandom)} >> $urandom_range(0, 60);
      if (b == 0) b = 64'h5;
      do_op("rand64", 1, op, a, b, m64(op, a, b), 1'b0, 19);
    end

    // reset during ITER with the request held across release
    drive(0, 1'b1, 2'b00, 64'hFFFF_FFF9, 64'h2);
    repeat (5) @(negedge clk);
    check("pre_rst_busy", busy32, 1'b1);
    resetn = 1'b0;
    #1;
    check("midrst_result32", res32, 32'h0);
    check("midrst_ready32", rdy32, 1'b0);
    check("midrst_busy32", busy32, 1'b0);
    check("midrst_dbz32", dbz32, 1'b0);
    check("midrst_result64", res64, 64'h0);
    @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (rdy32 || busy32) seen++;
    end
    check("post_rst_no_start", seen, 0);
    v32 = 1'b0;
    @(negedge clk);
    do_op("post_rst_div", 0, 2'b00, 64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFD, 1'b0, 35);

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
